// File: rtl/id_inst_queue_pkg.sv
// ----------------------------------------------------------------------------
// inst_queue_pkg
// Shared sizing defaults, pointer/count types, the per-lane instruction record
// and a 4-bit population count used by the decode-side instruction queue.
//   IQ_DEPTH / IQ_ENQ_W / IQ_DEQ_W : default queue depth and lane widths
//   ptr_t / cnt_t                  : pointer and occupancy types for IQ_DEPTH
//   decode_require_t               : one fetched instruction lane (valid, pc, inst)
//   bool_t                         : single-bit flag type
//   popcount4()                    : number of set bits in a 4-bit vector
// ----------------------------------------------------------------------------
package inst_queue_pkg;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_ENQ_W = 4;
  localparam int IQ_DEQ_W = 2;

  typedef logic [$clog2(IQ_DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(IQ_DEPTH):0]   cnt_t;

  typedef logic bool_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } decode_require_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/id_inst_queue_if.sv
// ----------------------------------------------------------------------------
// id_inst_queue_if
// Bundle between the IF/ID register, the instruction queue and the decoders.
//   flash       : synchronous discard of all queued entries
//   if_in[3:0]  : fetched lanes; .valid marks live lanes
//   stall_out   : queue cannot accept if_in this cycle
//   deq_cnt     : number of id_out lanes consumed by decode this cycle
//   id_out[]    : oldest queued entries, lane 0 oldest
//   occupancy   : registered entry count
//   full_cycles : stall cycle counter (only with INST_QUEUE_PERF_EN)
// Handshake: if_in is taken on a rising edge exactly when stall_out is low and
// flash is low; while stall_out is high the producer holds if_in stable. Decode
// reports consumption through deq_cnt, which is clamped to the visible entries.
// ----------------------------------------------------------------------------
interface id_inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int DEQ_W = IQ_DEQ_W
) ();

  bool_t                      flash;
  decode_require_t            if_in [4];
  bool_t                      stall_out;
  logic [1:0]                 deq_cnt;
  decode_require_t            id_out [DEQ_W];
  logic [$clog2(DEPTH):0]     occupancy;
`ifdef INST_QUEUE_PERF_EN
  logic [31:0]                full_cycles;
`endif

  modport master (
    output flash, if_in, deq_cnt,
    input  stall_out, id_out, occupancy
`ifdef INST_QUEUE_PERF_EN
    , input full_cycles
`endif
  );

  modport slave (
    input  flash, if_in, deq_cnt,
    output stall_out, id_out, occupancy
`ifdef INST_QUEUE_PERF_EN
    , output full_cycles
`endif
  );

endinterface

// File: rtl/id_inst_queue_compact.sv
// ----------------------------------------------------------------------------
// inst_queue_compact
// Combinational lane compaction: each valid lane's write offset is the number
// of valid lanes below it, so live lanes pack densely from the tail pointer.
//   i_valid[3:0]  : per-lane valid bits
//   o_offset[4]   : write offset from tail for each lane (meaningful if valid)
//   o_enq_n       : total valid lanes
// ----------------------------------------------------------------------------
module inst_queue_compact
  import inst_queue_pkg::*;
(
  input  logic [3:0] i_valid,
  output logic [1:0] o_offset [4],
  output logic [2:0] o_enq_n
);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      o_offset[i] = 2'(popcount4(i_valid & 4'((1 << i) - 1)));
    end
    o_enq_n = popcount4(i_valid);
  end

endmodule

// File: rtl/id_inst_queue.sv
// ----------------------------------------------------------------------------
// id_inst_queue
// Decode-side circular instruction queue behind the IF/ID register. Takes up
// to 4 compacted lanes per cycle and presents up to DEQ_W oldest entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   q (slave)  : flash, if_in, deq_cnt in; stall_out, id_out, occupancy out
// Optional macro INST_QUEUE_PERF_EN adds q.full_cycles, a free-running count
// of cycles with stall_out high (not cleared by flash).
// ----------------------------------------------------------------------------
module id_inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int ENQ_W = IQ_ENQ_W,
  parameter int DEQ_W = IQ_DEQ_W
) (
  input  logic             clk,
  input  logic             rst_n,
  id_inst_queue_if.slave   q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] lptr_t;
  typedef logic [CW-1:0] lcnt_t;

  decode_require_t r_mem [DEPTH];
  lptr_t           r_head;
  lptr_t           r_tail;
  lcnt_t           r_count;

  logic [3:0]      w_valid;
  logic [1:0]      w_off [4];
  logic [2:0]      w_enq_n;
  logic            w_stall;
  logic            w_enq_fire;
  lcnt_t           w_enq_n_eff;
  lcnt_t           w_deq_n;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_valid[i] = q.if_in[i].valid;
    end
  end

  inst_queue_compact u_compact (
    .i_valid  (w_valid),
    .o_offset (w_off),
    .o_enq_n  (w_enq_n)
  );

  // Depends only on the registered count so there is no combinational path
  // from if_in/deq_cnt back into the IF/ID stall.
  assign w_stall     = (lcnt_t'(DEPTH) - r_count) < lcnt_t'(ENQ_W);
  assign w_enq_fire  = !w_stall && !q.flash;
  assign w_enq_n_eff = w_enq_fire ? lcnt_t'(w_enq_n) : '0;

  // Decode may ask for more than is visible; clamp to lane width and count.
  always_comb begin
    w_deq_n = lcnt_t'(q.deq_cnt);
    if (w_deq_n > lcnt_t'(DEQ_W)) w_deq_n = lcnt_t'(DEQ_W);
    if (w_deq_n > r_count)        w_deq_n = r_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (q.flash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + lptr_t'(w_deq_n);
      r_tail  <= r_tail + lptr_t'(w_enq_n_eff);
      r_count <= r_count + w_enq_n_eff - w_deq_n;
    end
  end

  // Storage is not reset; offsets are distinct so lanes never collide, and
  // pointer addition wraps naturally across the end of the ring.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_enq_fire && w_valid[i]) begin
        r_mem[r_tail + lptr_t'(w_off[i])] <= q.if_in[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEQ_W; i++) begin
      q.id_out[i] = (lcnt_t'(i) < r_count) ? r_mem[r_head + lptr_t'(i)] : '0;
    end
  end

  assign q.stall_out = w_stall;
  assign q.occupancy = r_count;

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] r_full_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full_cycles <= '0;
    end else if (w_stall) begin
      r_full_cycles <= r_full_cycles + 32'd1;
    end
  end

  assign q.full_cycles = r_full_cycles;
`endif

endmodule
